// File: rtl/shift_pkg.sv
// Shared types for the shift unit and the core that issues shift operations.
//   shift_op_t    : SLL / SRL / SRA operation encoding.
//   shift_state_t : IDLE / BUSY / DONE control states of the shift unit.
//   ShamtW        : width of the shift-amount field.
package shift_pkg;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b10
   } shift_op_t;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } shift_state_t;

   localparam int unsigned ShamtW = 5;

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between the execute stage and the shift unit.
//   Request : in_valid, in_ready, op, a, shamt, flush
//   Response: out_valid, out_ready, result
//   master : issuing side (execute control / writeback consumer)
//   slave  : the shift unit itself
interface shift_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   import shift_pkg::*;

   logic              in_valid;
   logic              in_ready;
   shift_op_t         op;
   logic [XLEN-1:0]   a;
   logic [ShamtW-1:0] shamt;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   result;

   modport master (
      output in_valid, op, a, shamt, flush, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, a, shamt, flush, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/shift_step.sv
// Combinational partial shifter: shifts value_i by 0..STEP bit positions.
//   value_i : operand
//   op_i    : SLL / SRL / SRA
//   amt_i   : shift distance, 0..STEP
//   fill_i  : bit shifted in at the MSB for SRA
//   value_o : shifted value
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 4,
   parameter int unsigned AmtW = $clog2(STEP + 1)
) (
   input  logic [XLEN-1:0] value_i,
   input  shift_op_t       op_i,
   input  logic [AmtW-1:0] amt_i,
   input  logic            fill_i,
   output logic [XLEN-1:0] value_o
);

   logic [XLEN-1:0] hi_mask;

   // Ones in the bit positions vacated by a right shift of amt_i.
   assign hi_mask = ~({XLEN{1'b1}} >> amt_i);

   always_comb begin
      value_o = value_i;
      case (op_i)
         SLL:     value_o = value_i << amt_i;
         SRL:     value_o = value_i >> amt_i;
         SRA:     value_o = (value_i >> amt_i) | ({XLEN{fill_i}} & hi_mask);
         default: value_o = value_i;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift unit for SLL/SRL/SRA.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : shift_unit_if slave (request handshake, flush, result handshake)
// Default build shifts up to STEP bits per BUSY cycle through one shift_step.
// Defining SHIFT_UNIT_BARREL_EN computes the whole shift at accept with a
// barrel shifter and goes straight to DONE (STEP then has no effect).
module shift_unit
   import shift_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 4
) (
   input  logic         clk,
   input  logic         reset,
   shift_unit_if.slave  bus
);

   localparam int unsigned AmtW = $clog2(STEP + 1);

   shift_state_t      state_q, state_d;
   shift_op_t         op_q, op_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [ShamtW-1:0] rem_q, rem_d;
   logic              fill_q, fill_d;
   logic [AmtW-1:0]   step_n;
   logic [XLEN-1:0]   step_out;

   // n = min(STEP, remaining)
   always_comb begin
      if (32'(rem_q) < STEP) begin
         step_n = AmtW'(rem_q);
      end else begin
         step_n = AmtW'(STEP);
      end
   end

   shift_step #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_step (
      .value_i (acc_q),
      .op_i    (op_q),
      .amt_i   (step_n),
      .fill_i  (fill_q),
      .value_o (step_out)
   );

`ifdef SHIFT_UNIT_BARREL_EN
   logic [XLEN-1:0] barrel_out;

   always_comb begin
      barrel_out = bus.a;
      case (bus.op)
         SLL:     barrel_out = bus.a << bus.shamt;
         SRL:     barrel_out = bus.a >> bus.shamt;
         SRA:     barrel_out = (bus.a >> bus.shamt) |
                               ({XLEN{bus.a[XLEN-1]}} & ~({XLEN{1'b1}} >> bus.shamt));
         default: barrel_out = bus.a;
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      // Flush beats any accept or result handshake in the same cycle.
      if (bus.flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  op_d   = bus.op;
                  fill_d = bus.a[XLEN-1];
`ifdef SHIFT_UNIT_BARREL_EN
                  acc_d   = barrel_out;
                  rem_d   = '0;
                  state_d = StDone;
`else
                  acc_d   = bus.a;
                  rem_d   = bus.shamt;
                  state_d = (bus.shamt == '0) ? StDone : StBusy;
`endif
               end
            end
            StBusy: begin
               acc_d = step_out;
               rem_d = rem_q - ShamtW'(step_n);
               if (rem_d == '0) begin
                  state_d = StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= SLL;
         acc_q   <= '0;
         rem_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = acc_q;

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;
   import shift_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam int unsigned STEP = 4;

   typedef struct {
      logic [31:0] res;
      int          acc_cyc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
   bit   mon_en = 1'b0;
   bit   seen = 1'b0;
   logic [31:0] held;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift_unit_if #(.XLEN(XLEN)) bus ();

   shift_unit #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] ref_shift(input shift_op_t op, input logic [31:0] a,
                                             input int sh);
      logic signed [31:0] s;
      s = a;
      case (op)
         SLL:     return a << sh;
         SRL:     return a >> sh;
         default: return s >>> sh;
      endcase
   endfunction

   function automatic int ref_lat(input int sh);
`ifdef SHIFT_UNIT_BARREL_EN
      return (sh >= 0) ? 1 : 1;
`else
      return (sh + int'(STEP) - 1) / int'(STEP) + 1;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops the scoreboard whenever a result is presented.
   always @(negedge clk) begin
      if (mon_en && !reset && bus.out_valid) begin
         chk("in_ready_low_in_done", {31'b0, bus.in_ready}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
         end else begin
            if (!seen) begin
               chk("result", bus.result, sb[0].res);
               chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
               held = bus.result;
               seen = 1'b1;
            end else begin
               chk("result_stable", bus.result, held);
            end
            if (bus.out_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   task automatic issue(input shift_op_t op, input logic [31:0] a, input int sh, input bit track);
      bit done;
      exp_t e;
      done = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.shamt    = 5'(sh);
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1'b1;
            if (track) begin
               e.res     = ref_shift(op, a, sh);
               e.acc_cyc = cyc;
               e.lat     = ref_lat(sh);
               sb.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
      // Scramble the request lines; the unit must have latched them already.
      bus.in_valid = 1'b0;
      bus.op       = shift_op_t'($urandom_range(0, 2));
      bus.a        = $urandom;
      bus.shamt    = 5'($urandom);
      if (!done) fail_now("accept");
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         fail_now("drain");
         sb.delete();
         seen = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ov;
      bit got;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.op       = SLL;
      bus.a        = '0;
      bus.shamt    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      mon_en = 1'b1;

      issue(SRL, 32'd42, 1, 1'b1);
      drain();
      issue(SRL, 32'd42, 3, 1'b1);
      drain();
      issue(SRA, 32'h8000_0000, 31, 1'b1);
      drain();

      // Back-pressure: result and out_valid must hold while out_ready is low.
      rdy_mode = 2;
      issue(SLL, 32'd1, 31, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.out_valid;
      end
      if (!got) fail_now("bp_out_valid");
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid_held", {31'b0, bus.out_valid}, 32'd1);
         chk("bp_result_held", bus.result, 32'h8000_0000);
      end
      rdy_mode = 0;
      drain();

      issue(SLL, 32'hDEAD_BEEF, 0, 1'b1);
      drain();

      // Flush during the second BUSY cycle.
      mon_en   = 1'b0;
      rdy_mode = 2;
      ov       = 1'b0;
      issue(SRA, 32'hF000_0000, 20, 1'b0);
      @(negedge clk);
      ov = ov | bus.out_valid;
      @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(negedge clk);
      ov = ov | bus.out_valid;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
`ifndef SHIFT_UNIT_BARREL_EN
      chk("flush_no_out_valid_before", {31'b0, ov}, 32'd0);
`endif
      rdy_mode = 0;
      mon_en   = 1'b1;
      issue(SRL, 32'd42, 2, 1'b1);
      drain();

      // Flush beats a simultaneous accept.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      bus.op       = SLL;
      bus.a        = 32'd5;
      bus.shamt    = 5'd0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      @(negedge clk);
      chk("flush_vs_accept_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("flush_vs_accept_out_valid", {31'b0, bus.out_valid}, 32'd0);

      // Reset in the middle of a long shift.
      mon_en   = 1'b0;
      rdy_mode = 2;
      issue(SLL, 32'd1, 31, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("midreset_result", bus.result, 32'd0);
      rdy_mode = 0;
      mon_en   = 1'b1;
      issue(SRL, 32'd42, 1, 1'b1);
      drain();

      // Random operations with random back-pressure.
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         issue(shift_op_t'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 31)), 1'b1);
      end
      drain();
      rdy_mode = 0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter XLEN, 32, operand/result width in bits.
REQ-002 Parameter STEP, 4, bits shifted per BUSY cycle; legal values 1, 2, 4, 8, 16.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  operation request from decode/execute control.
REQ-006 Port in_ready  output  1  unit can accept a request this cycle.
REQ-007 Port op  input  shift_op_t (2)  SLL, SRL or SRA.
REQ-008 Port a  input  XLEN  value to shift (rs1).
REQ-009 Port shamt  input  5  shift amount (imm[4:0] or rs2[4:0]).
REQ-010 Port flush  input  1  abort any in-flight operation.
REQ-011 Port out_valid  output  1  result available.
REQ-012 Port out_ready  input  1  consumer (ALUWB path) takes result.
REQ-013 Port result  output  XLEN  shifted value, held stable while out_valid=1.

Function
REQ-014 States IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Accept when in_valid & in_ready: latch op, a into acc, shamt into remaining; next state BUSY if shamt!=0, else DONE.
REQ-016 Each BUSY cycle shifts acc by n=min(STEP, remaining) per op and decrements remaining by n; when remaining reaches 0, next state DONE.
REQ-017 SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates the latched a[XLEN-1].
REQ-018 Latency accept-edge to out_valid = ceil(shamt/STEP)+1 cycles; shamt=0 gives 1 cycle, result=a.
REQ-019 DONE holds result and out_valid until out_ready=1, then IDLE on next edge; no new accept in the same cycle as DONE->IDLE.
REQ-020 flush=1 forces IDLE next edge from any state, discards result; flush wins over simultaneous in_valid accept and out_ready.
REQ-021 Inputs op, a, shamt are sampled only at accept; later changes have no effect.
REQ-022 shamt bits above [4:0] do not exist on the port; values 0..31 all legal, no wrap beyond 31.

Reset
REQ-023 reset=1 at a rising edge forces IDLE, acc=0, remaining=0, result=0, out_valid=0, in_ready=1 next cycle, regardless of state, including mid-BUSY.
REQ-024 reset takes priority over flush and all handshakes.

Configuration
REQ-025 Macro SHIFT_UNIT_BARREL_EN defined: accepted operation computed by a full single-cycle barrel shifter, next state always DONE, latency 1 cycle for any shamt, BUSY unreachable, STEP ignored.
REQ-026 Macro undefined: iterative behaviour of REQ-016/018 only; no barrel shifter logic synthesized.
REQ-027 Handshake, flush and reset behaviour identical in both builds.

Structure
REQ-028 shift_op_t enum (SLL=2'b00, SRL=2'b01, SRA=2'b10) and state enum shift_state_t live in shared package shift_pkg, imported by the core and this unit.
REQ-029 One sub-module shift_step: combinational shift of XLEN value by 0..STEP bits per op and fill bit, instantiated once in the BUSY datapath.

Verification
REQ-030 SRL a=42, shamt=1, STEP=4 -> out_valid 2 cycles after accept, result=21.
REQ-031 SRL a=42, shamt=3 then SRA a=0x80000000, shamt=31 -> result 5, then 0xFFFFFFFF after 9 cycles (8 BUSY + 1).
REQ-032 SLL a=1, shamt=31; out_ready held 0 for 5 cycles -> result=0x80000000 stable, out_valid high throughout, in_ready=0 until released.
REQ-033 SLL a=0xDEADBEEF, shamt=0 -> result=0xDEADBEEF 1 cycle after accept, no BUSY cycle.
REQ-034 SRA a=0xF0000000, shamt=20; flush at 2nd BUSY cycle -> IDLE next edge, out_valid never asserted; next request SRL 42 by 2 -> 10.
REQ-035 reset pulsed mid-BUSY -> IDLE, result=0, in_ready=1 next cycle; repeat REQ-030 with SHIFT_UNIT_BARREL_EN defined -> all latencies 1 cycle.
